rtype_encoder: RTL and testbench

- Inverse of the funct7/funct3 decode path: converts a stream of ALU operations plus register indices into 32-bit RV32I R-type instruction words.
- Writes the words into instruction memory at sequential addresses over a valid/ready write port.
- Used by the self-test and program-load path to generate instruction images that the decode stage then consumes.
- Contains a small FIFO, an address counter and a run-control FSM.

---
 rtl/rtype_encoder_pkg.sv | 73 +++++++
 rtl/rtype_encoder_if.sv | 26 ++
 rtl/rtype_encoder_sync_fifo.sv | 48 ++++
 rtl/rtype_encoder.sv | 140 ++++++++++++++
 tb/tb_rtype_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtype_encoder_pkg.sv
// Shared ISA constants for the R-type encoder: ALU op codes, funct3/funct7
// fields, opcode, NOP word, FSM state type and the combinational encode helper.
package rtype_encoder_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;
    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

    // ST_PAD is only reachable when the NOP padding feature is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_PAD,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    // Maps an ALU op plus register indices onto an R-type word; ok=0 for
    // op codes that have no R-type encoding.
    function automatic enc_t encode_rtype(input logic [3:0] alu_op,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        enc_t       r;
        logic [2:0] f3;
        logic [6:0] f7;
        f3   = FUNCT3_ADD_SUB;
        f7   = FUNCT7_BASE;
        r.ok = 1'b1;
        case (alu_op)
            ALU_ADD:  f3 = FUNCT3_ADD_SUB;
            ALU_SUB:  begin f3 = FUNCT3_ADD_SUB; f7 = FUNCT7_ALT; end
            ALU_SLL:  f3 = FUNCT3_SLL;
            ALU_SLT:  f3 = FUNCT3_SLT;
            ALU_SLTU: f3 = FUNCT3_SLTU;
            ALU_XOR:  f3 = FUNCT3_XOR;
            ALU_SRL:  f3 = FUNCT3_SRL_SRA;
            ALU_SRA:  begin f3 = FUNCT3_SRL_SRA; f7 = FUNCT7_ALT; end
            ALU_OR:   f3 = FUNCT3_OR;
            ALU_AND:  f3 = FUNCT3_AND;
            default:  r.ok = 1'b0;
        endcase
        r.word = {f7, rs2, rs1, f3, rd, OPCODE_RTYPE};
        return r;
    endfunction

endpackage

// File: rtl/rtype_encoder_if.sv
// Bus bundles of the R-type encoder: the operation input stream (producer is
// master) and the instruction-memory write port (encoder is master).
interface rtype_encoder_op_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_alu_op;
    logic [4:0] in_rd;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic       in_last;

    modport master (output in_valid, in_alu_op, in_rd, in_rs1, in_rs2, in_last,
                    input  in_ready);
    modport slave  (input  in_valid, in_alu_op, in_rd, in_rs1, in_rs2, in_last,
                    output in_ready);
endinterface

interface rtype_encoder_wr_if #(parameter int ADDR_W = 10);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input  wr_ready);
    modport slave  (input  wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/rtype_encoder_sync_fifo.sv
// Single-clock FIFO holding encoded words. Pointers carry one wrap bit so
// full/empty need no separate counter; flush empties it in one cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wptr_q, rptr_q;
    logic             push_ok, pop_ok;

    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[PW-1:0]];

    // Pointer update; flush has priority over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/rtype_encoder.sv
// R-type instruction encoder: turns ALU ops into RV32I words and streams them
// to instruction memory at sequential addresses from BASE_ADDR.
// Optional feature macro: RTYPE_ENCODER_NOP_PAD_EN appends one NOP word
// after the last program word.
module rtype_encoder
    import rtype_encoder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    rtype_encoder_op_if.slave   op,
    rtype_encoder_wr_if.master  wr,
    output logic                busy,
    output logic                done,
    output logic                err_op,
    output logic                overflow,
    output logic [ADDR_W:0]     count
);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d, ovf_q, ovf_d;

    logic              fifo_full, fifo_empty, fifo_flush;
    logic [31:0]       fifo_head;
    logic              accept, push, pop, wr_fire, pad_active;
    enc_t              enc;

    assign enc         = encode_rtype(op.in_alu_op, op.in_rd, op.in_rs1, op.in_rs2);
    assign op.in_ready = (state_q == ST_STREAM) && !fifo_full && !ovf_q;
    assign accept      = op.in_valid && op.in_ready;
    assign push        = accept && enc.ok;

`ifdef RTYPE_ENCODER_NOP_PAD_EN
    assign pad_active = (state_q == ST_PAD);
`else
    assign pad_active = 1'b0;
`endif

    // Head-of-FIFO data is masked to zero when nothing is offered so no stale
    // word is visible after reset or flush.
    assign wr.wr_valid = !fifo_empty || pad_active;
    assign wr.wr_data  = !fifo_empty ? fifo_head : (pad_active ? NOP_WORD : 32'h0);
    assign wr.wr_addr  = addr_q;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign pop         = wr_fire && !fifo_empty;

    assign busy     = (state_q == ST_STREAM) || (state_q == ST_DRAIN) || (state_q == ST_PAD);
    assign done     = (state_q == ST_DONE);
    assign err_op   = err_q;
    assign overflow = ovf_q;
    assign count    = count_q;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (push),
        .din_i   (enc.word),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Run control, address/count bookkeeping and sticky flags; a write to the
    // top address overrides every other transition and ends the run.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_STREAM;
                    addr_d     = BASE;
                    count_d    = '0;
                    err_d      = 1'b0;
                    ovf_d      = 1'b0;
                    fifo_flush = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept && op.in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
`ifdef RTYPE_ENCODER_NOP_PAD_EN
                    state_d = ST_PAD;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_PAD: begin
                if (wr_fire) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && !enc.ok) err_d = 1'b1;
        if (wr_fire) begin
            count_d = count_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
                ovf_d      = 1'b1;
                fifo_flush = 1'b1;
                state_d    = ST_DONE;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rtype_encoder.sv
// Self-checking bench for rtype_encoder: directed scenarios plus randomized
// programs compared against a queue-based reference model.
module tb_rtype_encoder;
    import rtype_encoder_pkg::*;

`ifdef RTYPE_ENCODER_NOP_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, start_ov;
    logic [1:0] rdy_mode;

    rtype_encoder_op_if                 op_a ();
    rtype_encoder_wr_if #(.ADDR_W(10))  wr_a ();
    logic        busy_a, done_a, err_a, ovf_a;
    logic [10:0] count_a;

    rtype_encoder_op_if                 op_b ();
    rtype_encoder_wr_if #(.ADDR_W(3))   wr_b ();
    logic        busy_b, done_b, err_b, ovf_b;
    logic [3:0]  count_b;

    rtype_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op_a), .wr(wr_a),
        .busy(busy_a), .done(done_a), .err_op(err_a), .overflow(ovf_a), .count(count_a)
    );

    rtype_encoder #(.DEPTH(4), .ADDR_W(3), .BASE_ADDR(6)) dut_ov (
        .clk(clk), .rst_n(rst_n), .start(start_ov), .op(op_b), .wr(wr_b),
        .busy(busy_b), .done(done_b), .err_op(err_b), .overflow(ovf_b), .count(count_b)
    );

    assign wr_b.wr_ready = 1'b1;

    // wr_ready: 0 = held low, 1 = held high, 2 = random per cycle
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            2'd0:    wr_a.wr_ready = 1'b0;
            2'd1:    wr_a.wr_ready = 1'b1;
            default: wr_a.wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int          obs_addr_a[$], obs_addr_b[$];
    logic [31:0] obs_data_a[$], obs_data_b[$];

    always @(negedge clk) begin
        if (wr_a.wr_valid && wr_a.wr_ready) begin
            obs_addr_a.push_back(int'(wr_a.wr_addr));
            obs_data_a.push_back(wr_a.wr_data);
        end
        if (wr_b.wr_valid && wr_b.wr_ready) begin
            obs_addr_b.push_back(int'(wr_b.wr_addr));
            obs_data_b.push_back(wr_b.wr_data);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int F3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int F7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};

    int          p_op[$], p_rd[$], p_rs1[$], p_rs2[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_err, exp_ovf;

    function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1, input int rs2);
        return 32'(F7[op] * 33554432 + rs2 * 1048576 + rs1 * 32768 + F3[op] * 4096 + rd * 128 + 51);
    endfunction

    task automatic clear_prog();
        p_op.delete(); p_rd.delete(); p_rs1.delete(); p_rs2.delete();
    endtask

    task automatic add_op(input int op, input int rd, input int rs1, input int rs2);
        p_op.push_back(op); p_rd.push_back(rd); p_rs1.push_back(rs1); p_rs2.push_back(rs2);
    endtask

    task automatic add_rand_op(input int max_op);
        add_op(int'($urandom_range(0, max_op)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    endtask

    // Valid ops occupy consecutive addresses; writing the top address ends the run.
    task automatic build_exp(input int base, input int amax);
        int a;
        exp_addr.delete(); exp_data.delete();
        exp_err = 0; exp_ovf = 0; a = base;
        foreach (p_op[i]) begin
            if (p_op[i] > 9) exp_err = 1;
            else if (!exp_ovf) begin
                exp_addr.push_back(a);
                exp_data.push_back(ref_word(p_op[i], p_rd[i], p_rs1[i], p_rs2[i]));
                if (a == amax) exp_ovf = 1; else a++;
            end
        end
        if (PAD == 1 && !exp_ovf) begin
            exp_addr.push_back(a);
            exp_data.push_back(32'h0000_0013);
            if (a == amax) exp_ovf = 1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int i, input bit last);
        op_a.in_alu_op = 4'(p_op[i]);
        op_a.in_rd     = 5'(p_rd[i]);
        op_a.in_rs1    = 5'(p_rs1[i]);
        op_a.in_rs2    = 5'(p_rs2[i]);
        op_a.in_last   = last;
    endtask

    task automatic wait_accept_a(input string tag);
        int t;
        op_a.in_valid = 1'b1;
        t = 0;
        while (!op_a.in_ready && t < 200) begin tick(); t++; end
        if (t >= 200) chk({tag, "_accept_timeout"}, 64'(op_a.in_ready), 64'd1);
        tick();
        op_a.in_valid = 1'b0;
        op_a.in_last  = 1'b0;
    endtask

    task automatic start_a();
        obs_addr_a.delete(); obs_data_a.delete();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int t;
        t = 0;
        while (!done_a && t < 500) begin tick(); t++; end
        if (t >= 500) chk({tag, "_done_timeout"}, 64'(done_a), 64'd1);
    endtask

    task automatic send_prog_a(input string tag);
        for (int i = 0; i < p_op.size(); i++) begin
            load_a(i, i == p_op.size() - 1);
            wait_accept_a(tag);
        end
    endtask

    task automatic compare_a(input string tag);
        int n;
        chk({tag, "_nwr"}, 64'(obs_addr_a.size()), 64'(exp_addr.size()));
        n = (obs_addr_a.size() < exp_addr.size()) ? obs_addr_a.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(obs_addr_a[i]), 64'(exp_addr[i]));
            chk($sformatf("%s_data%0d", tag, i), 64'(obs_data_a[i]), 64'(exp_data[i]));
        end
        chk({tag, "_count"}, 64'(count_a), 64'(exp_addr.size()));
        chk({tag, "_err"},   64'(err_a),   64'(exp_err));
        chk({tag, "_ovf"},   64'(ovf_a),   64'(exp_ovf));
        chk({tag, "_done"},  64'(done_a),  64'd1);
        chk({tag, "_busy"},  64'(busy_a),  64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_valid"}, 64'(wr_a.wr_valid), 64'd0);
        chk({tag, "_wr_addr"},  64'(wr_a.wr_addr),  64'd0);
        chk({tag, "_wr_data"},  64'(wr_a.wr_data),  64'd0);
        chk({tag, "_in_ready"}, 64'(op_a.in_ready), 64'd0);
        chk({tag, "_busy"},     64'(busy_a),        64'd0);
        chk({tag, "_done"},     64'(done_a),        64'd0);
        chk({tag, "_err"},      64'(err_a),         64'd0);
        chk({tag, "_ovf"},      64'(ovf_a),         64'd0);
        chk({tag, "_count"},    64'(count_a),       64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        bit r;

        rst_n = 1'b1; start = 1'b0; start_ov = 1'b0; rdy_mode = 2'd1;
        op_a.in_valid = 1'b0; op_a.in_alu_op = '0; op_a.in_rd = '0;
        op_a.in_rs1 = '0; op_a.in_rs2 = '0; op_a.in_last = 1'b0;
        op_b.in_valid = 1'b0; op_b.in_alu_op = '0; op_b.in_rd = '0;
        op_b.in_rs1 = '0; op_b.in_rs2 = '0; op_b.in_last = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();
        chk_all_zero("idle");

        // single ADD
        clear_prog(); add_op(0, 1, 2, 3); build_exp(0, 1023);
        start_a(); send_prog_a("add"); wait_done_a("add"); compare_a("add");
        if (obs_data_a.size() > 0) chk("add_word", 64'(obs_data_a[0]), 64'h003100B3);
        chk("add_count_abs", 64'(count_a), 64'(1 + PAD));
        if (PAD == 1 && obs_data_a.size() == 2) chk("add_nop", 64'(obs_data_a[1]), 64'h13);

        // SUB then SRA, with a start pulse mid-stream that must be ignored
        clear_prog(); add_op(1, 5, 6, 7); add_op(7, 1, 1, 2); build_exp(0, 1023);
        start_a();
        load_a(0, 1'b0); wait_accept_a("subsra");
        start = 1'b1; tick(); start = 1'b0;
        load_a(1, 1'b1); wait_accept_a("subsra");
        wait_done_a("subsra"); compare_a("subsra");
        if (obs_data_a.size() >= 2) begin
            chk("sub_word", 64'(obs_data_a[0]), 64'h407302B3);
            chk("sra_word", 64'(obs_data_a[1]), 64'h4020D0B3);
        end

        // backpressure: 5 ops offered with wr_ready low
        rdy_mode = 2'd0; tick(); tick();
        clear_prog(); for (int k = 0; k < 5; k++) add_rand_op(9); build_exp(0, 1023);
        start_a();
        i = 0; load_a(0, 1'b0); op_a.in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            r = op_a.in_ready;
            tick();
            if (r && i < 4) begin i++; load_a(i, i == 4); end
        end
        chk("bp_accepts", 64'(i), 64'd4);
        chk("bp_ready",   64'(op_a.in_ready), 64'd0);
        chk("bp_valid",   64'(wr_a.wr_valid), 64'd1);
        chk("bp_addr",    64'(wr_a.wr_addr), 64'd0);
        chk("bp_data",    64'(wr_a.wr_data), 64'(exp_data[0]));
        repeat (3) tick();
        chk("bp_addr_hold", 64'(wr_a.wr_addr), 64'd0);
        chk("bp_data_hold", 64'(wr_a.wr_data), 64'(exp_data[0]));
        rdy_mode = 2'd1;
        wait_accept_a("bp");
        wait_done_a("bp"); compare_a("bp");

        // unsupported op between two ADDs
        clear_prog(); add_op(0, 1, 2, 3); add_op(15, 4, 5, 6); add_op(0, 7, 8, 9);
        build_exp(0, 1023);
        start_a(); send_prog_a("inv"); wait_done_a("inv"); compare_a("inv");
        chk("inv_err_abs",   64'(err_a),   64'd1);
        chk("inv_count_abs", 64'(count_a), 64'(2 + PAD));

        // address boundary on the ADDR_W=3, BASE_ADDR=6 instance
        clear_prog(); for (int k = 0; k < 4; k++) add_rand_op(9); build_exp(6, 7);
        obs_addr_b.delete(); obs_data_b.delete();
        start_ov = 1'b1; tick(); start_ov = 1'b0;
        i = 0; op_b.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (i < 4) begin
                op_b.in_alu_op = 4'(p_op[i]); op_b.in_rd = 5'(p_rd[i]);
                op_b.in_rs1 = 5'(p_rs1[i]); op_b.in_rs2 = 5'(p_rs2[i]);
                op_b.in_last = (i == 3);
                r = op_b.in_ready;
                tick();
                if (r) i++;
            end else tick();
        end
        op_b.in_valid = 1'b0;
        chk("ov_accepts", 64'(i), 64'd3);
        chk("ov_nwr", 64'(obs_addr_b.size()), 64'd2);
        if (obs_addr_b.size() >= 2) begin
            chk("ov_addr0", 64'(obs_addr_b[0]), 64'd6);
            chk("ov_addr1", 64'(obs_addr_b[1]), 64'd7);
            chk("ov_data0", 64'(obs_data_b[0]), 64'(exp_data[0]));
            chk("ov_data1", 64'(obs_data_b[1]), 64'(exp_data[1]));
        end
        chk("ov_flag",  64'(ovf_b),         64'd1);
        chk("ov_ready", 64'(op_b.in_ready), 64'd0);
        chk("ov_done",  64'(done_b),        64'd1);
        chk("ov_busy",  64'(busy_b),        64'd0);
        chk("ov_count", 64'(count_b),       64'd2);
        chk("ov_wvld",  64'(wr_b.wr_valid), 64'd0);

        // reset while draining three queued words
        rdy_mode = 2'd0; tick(); tick();
        clear_prog(); for (int k = 0; k < 3; k++) add_rand_op(9);
        start_a(); send_prog_a("rstd");
        chk("rstd_busy", 64'(busy_a), 64'd1);
        chk("rstd_vld",  64'(wr_a.wr_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk_all_zero("rstd");
        rdy_mode = 2'd1; tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rstd_after_vld", 64'(wr_a.wr_valid), 64'd0);
        chk("rstd_nwr", 64'(obs_addr_a.size()), 64'd0);

        // randomized programs with random wr_ready
        rdy_mode = 2'd2;
        for (int k = 0; k < 8; k++) begin
            clear_prog();
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) add_rand_op(11);
            build_exp(0, 1023);
            start_a(); send_prog_a($sformatf("rnd%0d", k));
            wait_done_a($sformatf("rnd%0d", k));
            compare_a($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
